mem_port_arbiter: RTL and testbench

//  Shares one memory bus between the IF stage (instruction fetch) and the load/store stage.

---
 rtl/mem_port_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory bus between instruction fetch and load/store.
// Data wins ties unless fetch has been passed over STARVE_MAX times; every bus access has a timeout.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int TIMEOUT    = 15,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  // fetch requester
  input  logic                i_imem_stb,
  input  logic [ADDR_W-1:0]   i_iaddr,
  output logic [DATA_W-1:0]   o_inst,
  output logic                o_imem_ack,
  output logic                o_imem_err,
  // load/store requester
  input  logic                i_dmem_stb,
  input  logic                i_dmem_we,
  input  logic [ADDR_W-1:0]   i_daddr,
  input  logic [DATA_W-1:0]   i_dwdata,
  input  logic [DATA_W/8-1:0] i_dsel,
  output logic [DATA_W-1:0]   o_drdata,
  output logic                o_dmem_ack,
  output logic                o_dmem_err,
  // memory bus
  output logic                o_mem_stb,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_sel,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  input  logic                i_mem_ack,
  // FSM state for observation: 0=IDLE 1=BUS_I 2=BUS_D 3=RESP
  output logic [1:0]          o_dbg_state
);

  localparam int SEL_W = DATA_W / 8;
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int SV_W  = $clog2(STARVE_MAX + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT);
  localparam logic [SV_W-1:0] SV_LIMIT = SV_W'(STARVE_MAX);

  // Handshakes: a requester raises its strobe with stable fields and holds both
  // until its ack pulse; the bus side holds o_mem_stb/o_mem_* stable until i_mem_ack
  // or timeout, and i_mem_ack is only honoured while a bus access is open.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUS_I = 2'd1,
    BUS_D = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [TO_W-1:0]     to_cnt_q;
  logic [SV_W-1:0]     starve_q;
  logic                mem_stb_q;
  logic                mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [SEL_W-1:0]    mem_sel_q;
  logic [DATA_W-1:0]   inst_q;
  logic [DATA_W-1:0]   drdata_q;
  logic                imem_ack_q;
  logic                imem_err_q;
  logic                dmem_ack_q;
  logic                dmem_err_q;

  logic [TO_W-1:0]     to_cnt_d;
  logic [SV_W-1:0]     starve_d;
  logic                grant_d;
  logic                grant_i;
  logic                bus_timeout;

  assign to_cnt_d    = to_cnt_q + TO_W'(1);
  assign starve_d    = (starve_q == SV_LIMIT) ? starve_q : starve_q + SV_W'(1);
  assign bus_timeout = (to_cnt_d == TO_LIMIT);

  // Data wins a tie unless fetch has already been passed over STARVE_MAX times.
  assign grant_d = i_dmem_stb && !(i_imem_stb && (starve_q == SV_LIMIT));
  assign grant_i = i_imem_stb && !grant_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      to_cnt_q    <= '0;
      starve_q    <= '0;
      mem_stb_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      inst_q      <= '0;
      drdata_q    <= '0;
      imem_ack_q  <= 1'b0;
      imem_err_q  <= 1'b0;
      dmem_ack_q  <= 1'b0;
      dmem_err_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d) begin
            state_q     <= BUS_D;
            mem_stb_q   <= 1'b1;
            mem_we_q    <= i_dmem_we;
            mem_addr_q  <= i_daddr;
            mem_wdata_q <= i_dwdata;
            mem_sel_q   <= i_dsel;
            to_cnt_q    <= '0;
            starve_q    <= i_imem_stb ? starve_d : '0;
          end else if (grant_i) begin
            state_q     <= BUS_I;
            mem_stb_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= i_iaddr;
            mem_wdata_q <= '0;
            mem_sel_q   <= '1;
            to_cnt_q    <= '0;
            starve_q    <= '0;
          end
        end

        BUS_I, BUS_D: begin
          // A real ack in the final allowed cycle still counts as success.
          if (i_mem_ack) begin
            state_q   <= RESP;
            mem_stb_q <= 1'b0;
            if (state_q == BUS_I) begin
              inst_q     <= i_mem_rdata;
              imem_ack_q <= 1'b1;
            end else begin
              drdata_q   <= i_mem_rdata;
              dmem_ack_q <= 1'b1;
            end
          end else if (bus_timeout) begin
            state_q   <= RESP;
            mem_stb_q <= 1'b0;
            if (state_q == BUS_I) begin
              inst_q     <= '0;
              imem_ack_q <= 1'b1;
              imem_err_q <= 1'b1;
            end else begin
              drdata_q   <= '0;
              dmem_ack_q <= 1'b1;
              dmem_err_q <= 1'b1;
            end
          end else begin
            to_cnt_q <= to_cnt_d;
          end
        end

        RESP: begin
          // Strobes are not looked at here, so a requester still holding its
          // strobe during its own ack is not granted a second time.
          state_q    <= IDLE;
          imem_ack_q <= 1'b0;
          imem_err_q <= 1'b0;
          dmem_ack_q <= 1'b0;
          dmem_err_q <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_inst      = inst_q;
  assign o_imem_ack  = imem_ack_q;
  assign o_imem_err  = imem_err_q;
  assign o_drdata    = drdata_q;
  assign o_dmem_ack  = dmem_ack_q;
  assign o_dmem_err  = dmem_err_q;
  assign o_mem_stb   = mem_stb_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_sel   = mem_sel_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-timeline reference model
// (grant cycle, bus window length, ack cycle), plus an ack scoreboard.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 15;
  localparam int SM = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          i_imem_stb = 1'b0;
  logic [AW-1:0] i_iaddr = '0;
  logic [DW-1:0] o_inst;
  logic          o_imem_ack, o_imem_err;
  logic          i_dmem_stb = 1'b0;
  logic          i_dmem_we = 1'b0;
  logic [AW-1:0] i_daddr = '0;
  logic [DW-1:0] i_dwdata = '0;
  logic [SW-1:0] i_dsel = '0;
  logic [DW-1:0] o_drdata;
  logic          o_dmem_ack, o_dmem_err;
  logic          o_mem_stb, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [SW-1:0] o_mem_sel;
  logic [DW-1:0] i_mem_rdata = '0;
  logic          i_mem_ack = 1'b0;
  logic [1:0]    o_dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_imem_stb(i_imem_stb), .i_iaddr(i_iaddr), .o_inst(o_inst),
    .o_imem_ack(o_imem_ack), .o_imem_err(o_imem_err),
    .i_dmem_stb(i_dmem_stb), .i_dmem_we(i_dmem_we), .i_daddr(i_daddr),
    .i_dwdata(i_dwdata), .i_dsel(i_dsel), .o_drdata(o_drdata),
    .o_dmem_ack(o_dmem_ack), .o_dmem_err(o_dmem_err),
    .o_mem_stb(o_mem_stb), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_sel(o_mem_sel),
    .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- reference model state ----------------
  int n_vec = 0;
  int n_miss = 0;
  int cyc, idle_at;
  bit plan_act, plan_i, plan_err;
  int plan_start, plan_k;
  logic [AW-1:0] plan_addr;
  logic [DW-1:0] plan_wdata, plan_rdata;
  logic          plan_we;
  logic [SW-1:0] plan_sel;
  int starve_m;
  logic [DW-1:0] inst_m, drdata_m;
  bit i_pend, i_drop, d_pend, d_drop;
  int p_i, p_d, p_to, p_stray, p_drop;
  bit dir_mode;
  logic [DW+1:0] exp_q[$];   // {is_fetch, err, read data}
  byte ack_log[$];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_stb"}, o_mem_stb, 0);
    check_val({tag, "_we"}, o_mem_we, 0);
    check_val({tag, "_addr"}, o_mem_addr, 0);
    check_val({tag, "_wdata"}, o_mem_wdata, 0);
    check_val({tag, "_sel"}, o_mem_sel, 0);
    check_val({tag, "_iack"}, {o_imem_ack, o_imem_err}, 0);
    check_val({tag, "_dack"}, {o_dmem_ack, o_dmem_err}, 0);
    check_val({tag, "_inst"}, o_inst, 0);
    check_val({tag, "_drdata"}, o_drdata, 0);
    check_val({tag, "_state"}, o_dbg_state, 0);
  endtask

  // Compare DUT outputs of the current cycle with the model's timeline.
  task automatic sample_check();
    bit in_win, ack_cyc;
    logic [DW+1:0] e;
    in_win  = plan_act && (cyc > plan_start) && (cyc <= plan_start + plan_k);
    ack_cyc = plan_act && (cyc == plan_start + plan_k + 1);
    if (ack_cyc) begin
      if (plan_i) inst_m = plan_err ? '0 : plan_rdata;
      else        drdata_m = plan_err ? '0 : plan_rdata;
    end
    check_val("mem_stb", o_mem_stb, in_win);
    if (in_win) begin
      check_val("mem_addr", o_mem_addr, plan_addr);
      check_val("mem_we", o_mem_we, plan_we);
      check_val("mem_sel", o_mem_sel, plan_sel);
      if (!plan_i) check_val("mem_wdata", o_mem_wdata, plan_wdata);
    end
    check_val("imem_ack", o_imem_ack, ack_cyc && plan_i);
    check_val("imem_err", o_imem_err, ack_cyc && plan_i && plan_err);
    check_val("dmem_ack", o_dmem_ack, ack_cyc && !plan_i);
    check_val("dmem_err", o_dmem_err, ack_cyc && !plan_i && plan_err);
    check_val("inst", o_inst, inst_m);
    check_val("drdata", o_drdata, drdata_m);
    if (o_imem_ack || o_dmem_ack) begin
      ack_log.push_back(o_imem_ack ? "I" : "D");
      if (exp_q.size() == 0) begin
        check_val("sb_unexpected_ack", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("sb_record",
                  {o_imem_ack, o_imem_ack ? o_imem_err : o_dmem_err, o_imem_ack ? o_inst : o_drdata}, e);
      end
    end
    if (ack_cyc) begin
      plan_act = 1'b0;
      idle_at  = cyc + 1;
      if (plan_i) begin i_pend = 1'b0; i_drop = 1'b0; end
      else        begin d_pend = 1'b0; d_drop = 1'b0; end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive_inputs();
    bit in_win;
    if (!i_pend) begin
      if ($urandom_range(1, 100) <= p_i) begin
        i_pend  = 1'b1;
        i_drop  = 1'b0;
        i_iaddr = dir_mode ? 32'h100 : $urandom;
      end
    end else if (plan_act && plan_i && cyc > plan_start && !i_drop && $urandom_range(1, 100) <= p_drop) begin
      i_drop = 1'b1;
    end
    i_imem_stb = i_pend && !i_drop;

    if (!d_pend) begin
      if ($urandom_range(1, 100) <= p_d) begin
        d_pend    = 1'b1;
        d_drop    = 1'b0;
        i_dmem_we = dir_mode ? 1'b1 : 1'($urandom);
        i_daddr   = dir_mode ? 32'h2000 : $urandom;
        i_dwdata  = dir_mode ? 32'hDEADBEEF : $urandom;
        i_dsel    = dir_mode ? 4'h3 : 4'($urandom);
      end
    end else if (plan_act && !plan_i && cyc > plan_start && !d_drop && $urandom_range(1, 100) <= p_drop) begin
      d_drop = 1'b1;
    end
    i_dmem_stb = d_pend && !d_drop;

    // Arbitration rule applied once per IDLE cycle to the strobes just driven.
    if (!plan_act && cyc == idle_at) begin
      if (i_imem_stb || i_dmem_stb) begin
        plan_i = i_imem_stb && (!i_dmem_stb || starve_m == SM);
        if (plan_i)          starve_m = 0;
        else if (i_imem_stb) starve_m = (starve_m < SM) ? starve_m + 1 : SM;
        else                 starve_m = 0;
        plan_addr  = plan_i ? i_iaddr : i_daddr;
        plan_we    = plan_i ? 1'b0 : i_dmem_we;
        plan_sel   = plan_i ? 4'hF : i_dsel;
        plan_wdata = i_dwdata;
        if (dir_mode) begin
          plan_err   = 1'b0;
          plan_k     = 3;
          plan_rdata = 32'h00106293;
        end else begin
          plan_err   = ($urandom_range(1, 100) <= p_to);
          plan_rdata = $urandom;
          if (plan_err)                          plan_k = TO;
          else if ($urandom_range(1, 6) == 1)    plan_k = $urandom_range(TO - 1, TO);
          else                                   plan_k = $urandom_range(1, 4);
        end
        exp_q.push_back({plan_i, plan_err, plan_err ? 32'h0 : plan_rdata});
        plan_act   = 1'b1;
        plan_start = cyc;
      end else begin
        idle_at = cyc + 1;
      end
    end

    i_mem_ack   = 1'b0;
    i_mem_rdata = $urandom;
    in_win = plan_act && (cyc > plan_start) && (cyc <= plan_start + plan_k);
    if (plan_act && !plan_err && cyc == plan_start + plan_k) begin
      i_mem_ack   = 1'b1;
      i_mem_rdata = plan_rdata;
    end else if (!in_win && $urandom_range(1, 100) <= p_stray) begin
      i_mem_ack = 1'b1;
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    sample_check();
    drive_inputs();
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic set_knobs(input int pi, input int pd, input int pto, input int pst, input int pdr);
    p_i = pi; p_d = pd; p_to = pto; p_stray = pst; p_drop = pdr;
  endtask

  // Called at a negedge: deassert reset and restart the model timeline at cycle 0.
  task automatic reset_release();
    rst_n    = 1'b1;
    cyc      = 0;
    idle_at  = 0;
    plan_act = 1'b0;
    starve_m = 0;
    inst_m   = '0;
    drdata_m = '0;
    i_pend = 1'b0; i_drop = 1'b0; d_pend = 1'b0; d_drop = 1'b0;
    exp_q.delete();
    drive_inputs();
  endtask

  // ---------------- main sequence ----------------
  initial begin : main
    string pat;
    cyc = 0;
    dir_mode = 1'b1;
    set_knobs(100, 100, 0, 0, 0);
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset_release();

    // Both requesters always asking: data first, fetch forced after STARVE_MAX data grants.
    run(60);
    pat = "DDDDIDDDDI";
    check_val("order_len_ok", ack_log.size() >= 10, 1);
    for (int i = 0; i < 10; i++) check_val($sformatf("order%0d", i), ack_log[i], pat[i]);

    dir_mode = 1'b0;
    set_knobs(40, 50, 10, 20, 10);
    run(1500);

    // Data loads that never get a bus ack.
    set_knobs(0, 100, 100, 0, 0);
    run(60);

    // Heavy stray bus acks outside open accesses.
    set_knobs(20, 20, 0, 60, 0);
    run(400);

    // Reset while fetch owns the bus.
    set_knobs(100, 0, 100, 0, 0);
    for (int i = 0; i < 80 && !(plan_act && plan_i && cyc > plan_start + 2); i++) step();
    check_val("busy_before_reset", {o_mem_stb, o_dbg_state}, {1'b1, 2'd1});
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    i_mem_ack = 1'b0;
    @(negedge clk);
    check_all_zero("held_reset");
    set_knobs(100, 0, 0, 0, 0);
    reset_release();
    run(12);

    set_knobs(40, 40, 8, 15, 10);
    run(800);

    set_knobs(0, 0, 0, 0, 0);
    run(40);
    check_val("sb_drain", exp_q.size(), 0);
    check_val("final_idle", {o_mem_stb, o_dbg_state}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
